// File: rtl/b07_line_points.sv
// Collinear-point counter after ITC99 b07: walks an 8-pair ROM and counts pairs with 3*x+y == 0.
// Optional B07_OBS_EN: __obs=1 freezes every register (async reset still wins).
module b07_line_points (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] punti_retta,
    input  logic       __obs
);

    localparam logic [2:0] S_RESET      = 3'd0;
    localparam logic [2:0] S_START      = 3'd1;
    localparam logic [2:0] S_LOAD_X     = 3'd2;
    localparam logic [2:0] S_UPDATE_MAR = 3'd3;
    localparam logic [2:0] S_LOAD_Y     = 3'd4;
    localparam logic [2:0] S_CALC_RETTA = 3'd5;
    localparam logic [2:0] S_INCREMENT  = 3'd6;

    logic [2:0] r_state, w_state_nxt;
    logic [3:0] r_mar, w_mar_nxt;
    logic [7:0] r_x, w_x_nxt;
    logic [7:0] r_y, w_y_nxt;
    logic [7:0] r_t, w_t_nxt;
    logic [7:0] r_cont, w_cont_nxt;
    logic [7:0] r_punti, w_punti_nxt;
    logic [7:0] w_rom;
    logic [7:0] w_cont_inc;
    logic       w_freeze;

`ifdef B07_OBS_EN
    assign w_freeze = __obs;
`else
    logic w_unused_obs;
    assign w_unused_obs = __obs;
    assign w_freeze     = 1'b0;
`endif

    always_comb begin
        unique case (r_mar)
            4'd0:    w_rom = 8'd1;
            4'd1:    w_rom = 8'd255;
            4'd5:    w_rom = 8'd2;
            4'd9:    w_rom = 8'd2;
            4'd10:   w_rom = 8'd255;
            4'd11:   w_rom = 8'd5;
            4'd13:   w_rom = 8'd2;
            4'd15:   w_rom = 8'd2;
            default: w_rom = 8'd0;
        endcase
    end

    // x holds 3*x+y by the time S_INCREMENT runs
    assign w_cont_inc = r_cont + {7'd0, (r_x == 8'd0)};

    always_comb begin
        w_state_nxt = r_state;
        w_mar_nxt   = r_mar;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_t_nxt     = r_t;
        w_cont_nxt  = r_cont;
        w_punti_nxt = r_punti;
        case (r_state)
            S_RESET: w_state_nxt = S_START;
            S_START: begin
                if (start) begin
                    w_cont_nxt  = 8'd0;
                    w_mar_nxt   = 4'd0;
                    w_state_nxt = S_LOAD_X;
                end
            end
            S_LOAD_X: begin
                w_x_nxt     = w_rom;
                w_state_nxt = S_UPDATE_MAR;
            end
            S_UPDATE_MAR: begin
                w_mar_nxt   = r_mar + 4'd1;
                w_t_nxt     = r_x + r_x;
                w_state_nxt = S_LOAD_Y;
            end
            S_LOAD_Y: begin
                w_y_nxt     = w_rom;
                w_x_nxt     = r_x + r_t;
                w_state_nxt = S_CALC_RETTA;
            end
            S_CALC_RETTA: begin
                w_x_nxt     = r_x + r_y;
                w_state_nxt = S_INCREMENT;
            end
            S_INCREMENT: begin
                if (r_mar != 4'd15) begin
                    w_cont_nxt  = w_cont_inc;
                    w_mar_nxt   = r_mar + 4'd1;
                    w_state_nxt = S_LOAD_X;
                end else if (!start) begin
                    w_cont_nxt  = w_cont_inc;
                    w_punti_nxt = w_cont_inc;
                    w_state_nxt = S_START;
                end
            end
            default: w_state_nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_RESET;
            r_mar   <= 4'd0;
            r_x     <= 8'd0;
            r_y     <= 8'd0;
            r_t     <= 8'd0;
            r_cont  <= 8'd0;
            r_punti <= 8'd0;
        end else if (!w_freeze) begin
            r_state <= w_state_nxt;
            r_mar   <= w_mar_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_t     <= w_t_nxt;
            r_cont  <= w_cont_nxt;
            r_punti <= w_punti_nxt;
        end
    end

    assign punti_retta = r_punti;

endmodule

// File: tb/tb_b07_line_points.sv
// Scoreboard bench for b07_line_points: stimulus queues expected punti_retta values keyed by
// clock count; a negedge monitor pops and compares them.
module tb_b07_line_points;

    logic       clock;
    logic       reset;
    logic       start;
    logic       obs;
    logic [7:0] punti_retta;

    b07_line_points dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .punti_retta (punti_retta),
        .__obs       (obs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  val;
        string       name;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: entries are due at the negedge following their target rising edge.
    always @(negedge clock) begin
        exp_t e;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            tests++;
            if (e.cyc != cyc) begin
                fails++;
                $display("FAIL %s: check missed (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
            end else if (punti_retta !== e.val) begin
                fails++;
                $display("FAIL %s: punti_retta=%0d expected %0d", e.name, punti_retta, e.val);
            end
        end
    end

    // Each sync lands just after a negedge, k rising edges before the matching check.
    task automatic sync(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic expect_at(input int unsigned k, input logic [7:0] v, input string nm);
        exp_t e;
        e.cyc  = cyc + k;
        e.val  = v;
        e.name = nm;
        q.push_back(e);
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        obs   = 1'b0;

        sync(3);
        expect_at(1, 8'd0, "reset_hold");
        sync(2);
        reset = 1'b1;
        sync(1);

        // Idle in S_START
        expect_at(5, 8'd0, "idle_5");
        expect_at(12, 8'd0, "idle_12");
        expect_at(20, 8'd0, "idle_20");
        sync(20);

        // Start held high: run stalls in the last S_INCREMENT
        start = 1'b1;
        expect_at(45, 8'd0, "held_stall");
        expect_at(60, 8'd0, "held_wait");
        sync(60);
        start = 1'b0;
        expect_at(1, 8'd2, "held_release");
        sync(1);

        // Back-to-back run: previous result stays visible, cont restarts at 0
        start = 1'b1;
        expect_at(20, 8'd2, "b2b_mid");
        expect_at(41, 8'd2, "b2b_done");
        expect_at(50, 8'd2, "b2b_hold");
        sync(1);
        start = 1'b0;
        sync(49);

        // Run aborted by a mid-clock reset around cycle 20
        start = 1'b1;
        sync(1);
        start = 1'b0;
        sync(18);
        #6;
        reset = 1'b0;
        expect_at(0, 8'd0, "reset_async");
        sync(1);
        expect_at(2, 8'd0, "reset_held");
        sync(3);
        reset = 1'b1;
        sync(1);

        // Fresh timed run: start sampled on edge 1, final S_INCREMENT on edge 41
        start = 1'b1;
        expect_at(40, 8'd0, "fresh_pre");
        expect_at(41, 8'd2, "fresh_done");
        expect_at(50, 8'd2, "fresh_hold");
        sync(1);
        start = 1'b0;
`ifndef B07_OBS_EN
        sync(10);
        obs = 1'b1;
        sync(5);
        obs = 1'b0;
        sync(34);
`else
        sync(49);
`endif

        for (int i = 0; i < 100 && q.size() > 0; i++) @(negedge clock);
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            fails++;
            $display("FAIL %s: never checked (due cycle %0d, now %0d)", e.name, e.cyc, cyc);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/b07_line_points.md
Name: b07_line_points

Overview:
- Sequential counter of collinear points, after ITC99 b07.
- On a start request it walks a fixed 16-entry ROM as 8 (x,y) pairs.
- For each pair it evaluates 3*x + y mod 256 and counts the pairs that give 0.
- It publishes the count on punti_retta. Standalone benchmark core, driven directly by a stimulus harness.

Parameters:
- None. All widths and ROM contents are fixed.

Ports:
- clock  input  1  rising-edge system clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- start  input  1  level request to begin or finish a computation
- punti_retta  output  8  registered count of matching pairs from the last completed run
- __obs  input  1  observation input; functionally ignored unless the optional feature is compiled in

Behaviour:
- Registers:
  - state (7 states)
  - mar: 4-bit ROM address
  - x, y, t: 8-bit working values
  - cont: 8-bit counter
  - punti_retta: 8-bit output register
- All arithmetic is 8-bit, wrap mod 256.
- ROM[0..15] = 1,255,0,0,0,2,0,0,0,2,255,5,0,2,0,2.
- Reset (reset=0, async):
  - state=S_RESET.
  - punti_retta, cont, mar, x, y, t all 0.
- Each clock edge with reset=1 executes exactly one state action:
  - S_RESET: -> S_START.
  - S_START: if start=1 then cont<=0, mar<=0, -> S_LOAD_X; else stay. punti_retta holds.
  - S_LOAD_X: x<=ROM[mar]; -> S_UPDATE_MAR.
  - S_UPDATE_MAR: mar<=mar+1; t<=x+x; -> S_LOAD_Y.
  - S_LOAD_Y: y<=ROM[mar]; x<=x+t (so x=3*ROM[even]); -> S_CALC_RETTA.
  - S_CALC_RETTA: x<=x+y; -> S_INCREMENT.
  - S_INCREMENT, mar!=15: if x==0 then cont<=cont+1; mar<=mar+1; -> S_LOAD_X.
  - S_INCREMENT, mar==15 and start=0: punti_retta<=cont+(x==0 ? 1 : 0); cont updated identically; -> S_START.
  - S_INCREMENT, mar==15 and start=1: stay in S_INCREMENT with no register change, waiting for start to drop.
- Latency:
  - 1 cycle S_RESET.
  - 1 cycle in S_START with start=1.
  - 5 cycles per pair x 8 pairs = 40 cycles.
  - Result is visible after the edge where the final S_INCREMENT sees start=0.
- With the fixed ROM the result is always 2 (pairs 1 and 3 match).
- mar wraps 15->0 only via S_START reload; it never increments past 15.
- Reset mid-run aborts immediately and clears punti_retta to 0.
- start changes during S_LOAD_X..S_CALC_RETTA are ignored.
- A new run does not clear punti_retta until its own completion overwrites it.

Optional Feature:
- Macro B07_OBS_EN.
- When defined, __obs is a freeze control: while __obs=1 and reset=1, every register holds its value. Asynchronous reset still overrides.
- When undefined, __obs has no effect and the block behaves exactly as above.

Test Plan:
- Async reset: drive reset=0 mid-clock -> punti_retta=0 immediately. First cycle after release is S_RESET, then S_START.
- Idle: start=0 held for 20 cycles after reset -> punti_retta stays 0; state remains S_START.
- Single run: pulse start=1 for 1 cycle in S_START, then 0 -> punti_retta=2 exactly 41 cycles after the start sample, and holds 2 afterwards.
- Held start: keep start=1 throughout -> block stalls in S_INCREMENT with mar=15 and punti_retta=0. Dropping start -> punti_retta=2 on the next edge, then state returns to S_START.
- Back-to-back: a second run after the first -> punti_retta stays 2 during the run (cont restarts at 0) and ends at 2 again.
- Reset mid-run: assert reset at cycle 20 of a run -> all outputs 0. A fresh run afterwards -> punti_retta=2.
